// File: rtl/sysid_checker_if.sv
// sysid_checker_if
// Avalon-MM read-only bus between the system-ID checker (master) and the
// system-ID slave.
//   avm_address       master->slave  word select (0 = ID, 1 = timestamp)
//   avm_read          master->slave  read request
//   avm_waitrequest   slave->master  stall
//   avm_readdata      slave->master  32-bit read data
//   avm_readdatavalid slave->master  read response strobe
//
// Handshake: a read is accepted in any cycle where avm_read=1 and
// avm_waitrequest=0; the master holds avm_read and avm_address stable
// until then. The response comes later as a single avm_readdatavalid
// cycle carrying avm_readdata; a strobe in the acceptance cycle itself
// is never taken as the response.
interface sysid_checker_if;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_waitrequest,
        input  avm_readdata,
        input  avm_readdatavalid
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_waitrequest,
        output avm_readdata,
        output avm_readdatavalid
    );
endinterface

// File: rtl/sysid_checker.sv
// sysid_checker
// Reads the ID (address 0) and build timestamp (address 1) from the
// system-ID slave, compares both against the values this software image
// was built for, retries on mismatch or timeout and reports a sticky
// verdict.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   start_i           one-cycle request for a check (ignored while busy)
//   avm               Avalon-MM master side of sysid_checker_if
//   busy_o            check in progress
//   done_o            one-cycle pulse when the verdict is final
//   pass_o / fail_o   sticky verdict
//   timeout_err_o     a transfer of the last check timed out
//   id_value_o        last captured ID word
//   ts_value_o        last captured timestamp word
//   retry_count_o     retries used in the current or last check
//   state_o           FSM state, for observation
module sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'd151178878,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1526974626,
    parameter int unsigned TIMEOUT_CYCLES     = 255,
    parameter int unsigned MAX_RETRIES        = 3,
    parameter bit          AUTO_START         = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start_i,
    sysid_checker_if.master        avm,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   pass_o,
    output logic                   fail_o,
    output logic                   timeout_err_o,
    output logic [31:0]            id_value_o,
    output logic [31:0]            ts_value_o,
    output logic [1:0]             retry_count_o,
    output logic [2:0]             state_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_ID  = 3'd1,
        WT_ID  = 3'd2,
        RD_TS  = 3'd3,
        WT_TS  = 3'd4,
        CHECK  = 3'd5,
        FINISH = 3'd6
    } state_t;

    localparam logic [15:0] TMO    = 16'(TIMEOUT_CYCLES);
    localparam logic [1:0]  MAX_RC = 2'(MAX_RETRIES);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        pass_q, pass_d;
    logic        fail_q, fail_d;
    logic        tmo_q, tmo_d;
    logic        auto_q, auto_d;
    logic [1:0]  rc_q, rc_d;
    logic [31:0] id_q, id_d;
    logic [31:0] ts_q, ts_d;

    logic        expired;
    logic        attempt_fail;
    logic        read_c;
    logic        addr_c;

    // The cycle in which the counter sits at TIMEOUT_CYCLES is the last
    // chance: the read request is withdrawn, but a response in that same
    // cycle is still taken.
    assign expired = (cnt_q == TMO);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + 16'd1;
        pass_d       = pass_q;
        fail_d       = fail_q;
        tmo_d        = tmo_q;
        auto_d       = auto_q;
        rc_d         = rc_q;
        id_d         = id_q;
        ts_d         = ts_q;
        attempt_fail = 1'b0;
        read_c       = 1'b0;
        addr_c       = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = 16'd0;
                if (start_i || auto_q) begin
                    auto_d  = 1'b0;
                    pass_d  = 1'b0;
                    fail_d  = 1'b0;
                    tmo_d   = 1'b0;
                    rc_d    = 2'd0;
                    state_d = RD_ID;
                end
            end
            RD_ID: begin
                read_c = !expired;
                if (expired) begin
                    tmo_d        = 1'b1;
                    attempt_fail = 1'b1;
                end else if (!avm.avm_waitrequest) begin
                    state_d = WT_ID;
                end
            end
            WT_ID: begin
                if (avm.avm_readdatavalid) begin
                    id_d    = avm.avm_readdata;
                    cnt_d   = 16'd0;
                    state_d = RD_TS;
                end else if (expired) begin
                    tmo_d        = 1'b1;
                    attempt_fail = 1'b1;
                end
            end
            RD_TS: begin
                addr_c = 1'b1;
                read_c = !expired;
                if (expired) begin
                    tmo_d        = 1'b1;
                    attempt_fail = 1'b1;
                end else if (!avm.avm_waitrequest) begin
                    state_d = WT_TS;
                end
            end
            WT_TS: begin
                addr_c = 1'b1;
                if (avm.avm_readdatavalid) begin
                    ts_d    = avm.avm_readdata;
                    state_d = CHECK;
                end else if (expired) begin
                    tmo_d        = 1'b1;
                    attempt_fail = 1'b1;
                end
            end
            CHECK: begin
                cnt_d = 16'd0;
                if ((id_q == EXPECTED_ID) && (ts_q == EXPECTED_TIMESTAMP)) begin
                    pass_d  = 1'b1;
                    state_d = FINISH;
                end else begin
                    attempt_fail = 1'b1;
                end
            end
            FINISH: begin
                cnt_d   = 16'd0;
                state_d = IDLE;
            end
            default: begin
                cnt_d   = 16'd0;
                state_d = IDLE;
            end
        endcase

        // Mismatch and timeout share one retry path; the retry count can
        // never pass MAX_RETRIES, so it saturates there.
        if (attempt_fail) begin
            if (rc_q < MAX_RC) begin
                rc_d    = rc_q + 2'd1;
                cnt_d   = 16'd0;
                state_d = RD_ID;
            end else begin
                fail_d  = 1'b1;
                state_d = FINISH;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 16'd0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            tmo_q   <= 1'b0;
            auto_q  <= AUTO_START;
            rc_q    <= 2'd0;
            id_q    <= 32'd0;
            ts_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            tmo_q   <= tmo_d;
            auto_q  <= auto_d;
            rc_q    <= rc_d;
            id_q    <= id_d;
            ts_q    <= ts_d;
        end
    end

    // Bus controls decode straight from the state register, so an
    // asserted reset withdraws the read request without waiting for a clock.
    assign avm.avm_read    = read_c;
    assign avm.avm_address = addr_c;

    assign busy_o        = (state_q != IDLE);
    assign done_o        = (state_q == FINISH);
    assign pass_o        = pass_q;
    assign fail_o        = fail_q;
    assign timeout_err_o = tmo_q;
    assign id_value_o    = id_q;
    assign ts_value_o    = ts_q;
    assign retry_count_o = rc_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_sysid_checker.sv
`timescale 1ns/1ps
module tb_sysid_checker;

    localparam logic [31:0] EXP_ID = 32'd151178878;
    localparam logic [31:0] EXP_TS = 32'd1526974626;
    localparam logic [31:0] BAD_ID = 32'h12345678;
    localparam logic [31:0] STRAY  = 32'hDEADBEEF;
    localparam int          W      = 69;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RD_TS = 3'd3;
    localparam logic [2:0] S_WT_TS = 3'd4;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_i;
    logic        busy_o;
    logic        done_o;
    logic        pass_o;
    logic        fail_o;
    logic        timeout_err_o;
    logic [31:0] id_value_o;
    logic [31:0] ts_value_o;
    logic [1:0]  retry_count_o;
    logic [2:0]  state_o;

    sysid_checker_if bus();

    sysid_checker dut (
        .clk           (clk),
        .reset         (reset),
        .start_i       (start_i),
        .avm           (bus),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .pass_o        (pass_o),
        .fail_o        (fail_o),
        .timeout_err_o (timeout_err_o),
        .id_value_o    (id_value_o),
        .ts_value_o    (ts_value_o),
        .retry_count_o (retry_count_o),
        .state_o       (state_o)
    );

    // ---------------- clock / watchdog ----------------
    initial forever #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded 1 ms");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int n_cmp  = 0;
    int n_bad  = 0;
    int n_done = 0;

    // slave behaviour knobs
    int slv_wait     = 0;   // waitrequest cycles before each acceptance
    int bad_id_reads = 0;   // number of ID reads answered with BAD_ID
    bit inject_stray = 0;   // one strobe while an ID read is stalled

    function automatic logic [W-1:0] pack_exp(input logic p, input logic f, input logic t,
                                              input logic [1:0] rc, input logic [31:0] id,
                                              input logic [31:0] ts);
        return {p, f, t, rc, id, ts};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
    endtask

    task automatic wait_drain(input int budget, input string name);
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < budget) begin
            step();
            i++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: no done within %0d cycles, %0d verdicts outstanding",
                     name, budget, exp_q.size());
            exp_q.delete();
        end
        step();
        step();
    endtask

    task automatic wait_state(input logic [2:0] st, input int budget, input string name);
        int i;
        i = 0;
        while (state_o !== st && i < budget) begin
            step();
            i++;
        end
        check(name, {29'd0, state_o}, {29'd0, st});
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_read"},  {31'd0, bus.avm_read},    32'd0);
        check({tag, "_addr"},  {31'd0, bus.avm_address}, 32'd0);
        check({tag, "_busy"},  {31'd0, busy_o},          32'd0);
        check({tag, "_done"},  {31'd0, done_o},          32'd0);
        check({tag, "_pass"},  {31'd0, pass_o},          32'd0);
        check({tag, "_fail"},  {31'd0, fail_o},          32'd0);
        check({tag, "_tmo"},   {31'd0, timeout_err_o},   32'd0);
        check({tag, "_rc"},    {30'd0, retry_count_o},   32'd0);
        check({tag, "_id"},    id_value_o,               32'd0);
        check({tag, "_ts"},    ts_value_o,               32'd0);
        check({tag, "_state"}, {29'd0, state_o},         {29'd0, S_IDLE});
    endtask

    // ---------------- slave model ----------------
    // Evaluated mid-cycle: the strobe driven here is what the DUT sees at
    // the next rising edge, and acceptance is decided from this cycle's
    // read/waitrequest pair, answered in the following cycle.
    initial begin : slave
        int   wcnt;
        bit   pend;
        logic pend_addr;
        wcnt      = 0;
        pend      = 0;
        pend_addr = 1'b0;
        bus.avm_waitrequest   = 1'b0;
        bus.avm_readdatavalid = 1'b0;
        bus.avm_readdata      = 32'd0;
        forever begin
            @(negedge clk);
            if (reset) begin
                wcnt = 0;
                pend = 0;
                bus.avm_waitrequest   = 1'b0;
                bus.avm_readdatavalid = 1'b0;
                bus.avm_readdata      = 32'd0;
            end else begin
                bus.avm_readdatavalid = 1'b0;
                bus.avm_readdata      = 32'd0;
                if (pend) begin
                    bus.avm_readdatavalid = 1'b1;
                    if (pend_addr) begin
                        bus.avm_readdata = EXP_TS;
                    end else if (bad_id_reads > 0) begin
                        bus.avm_readdata = BAD_ID;
                        bad_id_reads--;
                    end else begin
                        bus.avm_readdata = EXP_ID;
                    end
                    pend = 0;
                end
                if (bus.avm_read) begin
                    if (wcnt < slv_wait) begin
                        bus.avm_waitrequest = 1'b1;
                        wcnt++;
                        if (inject_stray && !bus.avm_address && !bus.avm_readdatavalid) begin
                            bus.avm_readdatavalid = 1'b1;
                            bus.avm_readdata      = STRAY;
                            inject_stray          = 0;
                        end
                    end else begin
                        bus.avm_waitrequest = 1'b0;
                        wcnt      = 0;
                        pend      = 1;
                        pend_addr = bus.avm_address;
                    end
                end else begin
                    bus.avm_waitrequest = 1'b0;
                    wcnt = 0;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin : monitor
        logic [W-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (done_o === 1'b1) begin
                n_done++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: done=1 with no verdict queued");
                end else begin
                    e = exp_q.pop_front();
                    check("sb_pass", {31'd0, pass_o},        {31'd0, e[68]});
                    check("sb_fail", {31'd0, fail_o},        {31'd0, e[67]});
                    check("sb_tmo",  {31'd0, timeout_err_o}, {31'd0, e[66]});
                    check("sb_rc",   {30'd0, retry_count_o}, {30'd0, e[65:64]});
                    check("sb_id",   id_value_o,             e[63:32]);
                    check("sb_ts",   ts_value_o,             e[31:0]);
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin : main
        int n;
        int d0;
        reset   = 1'b1;
        start_i = 1'b0;
        repeat (3) step();
        check_reset_values("por");

        // auto-start on the first clock after release, matching slave
        exp_q.push_back(pack_exp(1'b1, 1'b0, 1'b0, 2'd0, EXP_ID, EXP_TS));
        reset = 1'b0;
        step();
        check("auto_start_read", {31'd0, bus.avm_read}, 32'd1);
        wait_drain(50, "auto_start");

        // zero-wait matching slave: exact cycle timing
        exp_q.push_back(pack_exp(1'b1, 1'b0, 1'b0, 2'd0, EXP_ID, EXP_TS));
        pulse_start();
        check("t1_read_id",    {31'd0, bus.avm_read},    32'd1);
        check("t1_addr_id",    {31'd0, bus.avm_address}, 32'd0);
        check("t1_busy",       {31'd0, busy_o},          32'd1);
        step();
        check("t1_wait_id",    {31'd0, bus.avm_read},    32'd0);
        step();
        check("t1_read_ts",    {31'd0, bus.avm_read},    32'd1);
        check("t1_addr_ts",    {31'd0, bus.avm_address}, 32'd1);
        step();
        step();
        check("t1_check_nodone", {31'd0, done_o}, 32'd0);
        step();
        check("t1_done",       {31'd0, done_o},          32'd1);
        check("t1_pass",       {31'd0, pass_o},          32'd1);
        step();
        check("t1_done_pulse", {31'd0, done_o},          32'd0);
        check("t1_pass_held",  {31'd0, pass_o},          32'd1);
        check("t1_busy_off",   {31'd0, busy_o},          32'd0);

        // ID always wrong: 1 + 3 attempts then fail
        bad_id_reads = 4;
        exp_q.push_back(pack_exp(1'b0, 1'b1, 1'b0, 2'd3, BAD_ID, EXP_TS));
        pulse_start();
        wait_drain(200, "bad_id");
        check("bad_id_reads_used", bad_id_reads, 32'd0);

        // permanent stall: 255-cycle read windows, 4 timeouts, fail
        slv_wait = 100000;
        exp_q.push_back(pack_exp(1'b0, 1'b1, 1'b1, 2'd3, BAD_ID, EXP_TS));
        pulse_start();
        n = 0;
        while (bus.avm_read === 1'b1 && n < 400) begin
            n++;
            step();
        end
        check("tmo_read_cycles", n, 32'd255);
        check("tmo_not_yet",     {31'd0, timeout_err_o}, 32'd0);
        step();
        check("tmo_flag",        {31'd0, timeout_err_o}, 32'd1);
        check("tmo_retry_read",  {31'd0, bus.avm_read},  32'd1);
        check("tmo_retry_count", {30'd0, retry_count_o}, 32'd1);
        wait_drain(1500, "stall");

        // response lands exactly when the counter reaches the limit
        slv_wait = 254;
        exp_q.push_back(pack_exp(1'b1, 1'b0, 1'b0, 2'd0, EXP_ID, EXP_TS));
        pulse_start();
        wait_drain(1000, "tmo_edge");

        // mismatch on attempt 1, match on attempt 2
        slv_wait     = 0;
        bad_id_reads = 1;
        exp_q.push_back(pack_exp(1'b1, 1'b0, 1'b0, 2'd1, EXP_ID, EXP_TS));
        pulse_start();
        wait_drain(100, "retry_pass");

        // reset during WT_TS, then auto-start check
        pulse_start();
        wait_state(S_WT_TS, 50, "rst_wt_reach");
        reset = 1'b1;
        #1;
        check_reset_values("rst_wt");
        step();
        step();
        exp_q.push_back(pack_exp(1'b1, 1'b0, 1'b0, 2'd0, EXP_ID, EXP_TS));
        reset = 1'b0;
        wait_drain(50, "rst_wt_auto");

        // reset while a stalled timestamp read is pending: read drops at once
        slv_wait = 3;
        pulse_start();
        wait_state(S_RD_TS, 50, "rst_rd_reach");
        check("rst_rd_read_before", {31'd0, bus.avm_read}, 32'd1);
        reset = 1'b1;
        #1;
        check("rst_rd_read_async", {31'd0, bus.avm_read}, 32'd0);
        check("rst_rd_busy",       {31'd0, busy_o},       32'd0);
        step();
        step();
        exp_q.push_back(pack_exp(1'b1, 1'b0, 1'b0, 2'd0, EXP_ID, EXP_TS));
        reset = 1'b0;
        wait_drain(80, "rst_rd_auto");

        // start held every cycle plus a stray strobe during the ID read
        slv_wait     = 2;
        inject_stray = 1;
        d0           = n_done;
        exp_q.push_back(pack_exp(1'b1, 1'b0, 1'b0, 2'd0, EXP_ID, EXP_TS));
        start_i = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            if (done_o === 1'b1) break;
        end
        start_i = 1'b0;
        repeat (5) step();
        check("spam_done_pulses", n_done - d0, 32'd1);
        check("stray_injected",   {31'd0, inject_stray}, 32'd0);
        check("spam_queue_empty", exp_q.size(), 32'd0);
        slv_wait = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sysid_checker.md
# sysid_checker

Avalon-MM master that reads the two words of the system-ID slave (ID at address 0, build timestamp at address 1) and compares them against the values the software image was built for. Sits between the boot/reset logic and the system-ID slave on the control bus. Sequences the reads, bounds each transfer with a timeout, retries on mismatch or timeout, and reports a sticky pass/fail verdict so the processor or the boot FSM can refuse to run on a mismatched FPGA image.

## Interface
- EXPECTED_ID, 151178878: 32-bit value required at address 0.
- EXPECTED_TIMESTAMP, 1526974626: 32-bit value required at address 1.
- TIMEOUT_CYCLES, 255: cycles allowed per transfer, counted from read assertion to readdatavalid; range 2..65535.
- MAX_RETRIES, 3: additional full check attempts after the first one fails; range 0..3.
- AUTO_START, 1: 1 means a check starts on the first clock after reset is released.
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse that requests a check; ignored while busy.
- avm_address  output  1  0 selects the ID word, 1 selects the timestamp word.
- avm_read  output  1  read request.
- avm_waitrequest  input  1  slave stall; the read is accepted in a cycle with avm_read=1 and waitrequest=0.
- avm_readdata  input  32  read data, valid when readdatavalid=1.
- avm_readdatavalid  input  1  read response strobe.
- busy  output  1  check in progress.
- done  output  1  one-cycle pulse when the verdict is final.
- pass  output  1  sticky; ID and timestamp both matched.
- fail  output  1  sticky; retries are exhausted.
- timeout_err  output  1  sticky; at least one transfer in the last check timed out.
- id_value  output  32  last ID word captured.
- ts_value  output  32  last timestamp word captured.
- retry_count  output  2  retries used in the current or last check.

## Operation
- States: IDLE, RD_ID, WT_ID, RD_TS, WT_TS, CHECK, FINISH.
- IDLE: if start=1, or on the pending auto-start, the block:
  - clears pass, fail, timeout_err and retry_count;
  - sets busy;
  - goes to RD_ID.
- RD_ID: drives avm_read=1 and avm_address=0, held stable until accepted. On acceptance it goes to WT_ID.
- WT_ID: on readdatavalid it captures avm_readdata into id_value and goes to RD_TS.
- RD_TS and WT_TS behave the same with address 1, capturing into ts_value, then go to CHECK.
- readdatavalid outside WT_ID or WT_TS is ignored.
- Timeout:
  - A 16-bit counter clears on entry to RD_ID or RD_TS and increments every cycle in RD_x and WT_x.
  - When it reaches TIMEOUT_CYCLES, the block drops avm_read, sets timeout_err, and treats the attempt as failed.
- CHECK (one cycle): match = (id_value==EXPECTED_ID) and (ts_value==EXPECTED_TIMESTAMP).
  - Match: set pass and go to FINISH.
  - No match with retry_count < MAX_RETRIES: increment retry_count and go to RD_ID.
  - No match with retries exhausted: set fail and go to FINISH.
- A timed-out attempt follows the same retry/fail path directly from the state where it timed out.
- FINISH (one cycle): done=1, busy=0 on exit, return to IDLE.
- pass and fail are never both 1.
- start while busy is dropped, not queued.
- The ID and timestamp comparisons are full 32-bit equality.
- retry_count saturates at MAX_RETRIES.

## Timing
- Reset values:
  - avm_read=0, avm_address=0, busy=0, done=0, pass=0, fail=0, timeout_err=0, retry_count=0, id_value=0, ts_value=0.
  - State is IDLE.
  - Auto-start pending = AUTO_START.
- Reset asserted mid-transfer: avm_read drops immediately (asynchronously) and the check is abandoned.
- start sampled at cycle T: avm_read=1 at T+1 and busy=1 at T+1.
- Zero-wait slave with readdatavalid one cycle after acceptance:
  - address-0 read at T+1;
  - address-1 read at T+3;
  - CHECK at T+5;
  - done=1 at T+6, with pass or fail valid in the same cycle and held afterwards.
- readdatavalid arriving in the same cycle as acceptance is not used. The earliest response consumed is the cycle after acceptance.
- avm_address changes only while avm_read=0, or in the cycle after an acceptance.
- Timeout boundary:
  - readdatavalid in the same cycle the counter reaches TIMEOUT_CYCLES counts as success.
  - The timeout takes effect on the following cycle.

## Test plan
- Matching slave (ID 151178878, timestamp 1526974626, zero wait, latency 1), start at cycle 10 -> reads at 11 and 13, done=1 and pass=1 at 16, retry_count=0.
- Slave returns ID 0x12345678 -> four attempts (1 + MAX_RETRIES), then fail=1 and retry_count=3; pass stays 0; id_value=0x12345678.
- waitrequest held high for 300 cycles -> avm_read drops after 255 cycles, timeout_err=1, retry begins; with the stall permanent, fail=1 after the 4th timeout.
- Slave mismatches on attempt 1 and matches on attempt 2 -> pass=1, retry_count=1, fail=0.
- reset pulsed while in WT_TS -> all outputs return to reset values; with AUTO_START=1, a new check begins on the first cycle after release and passes.
- start pulsed every cycle during a check, and a stray readdatavalid injected in RD_ID -> exactly one done pulse, and id_value is unaffected by the stray strobe.
